// File: rtl/axi_cfg_sequencer.sv
// rtl/axi_cfg_sequencer.sv - AXI4 register-write sequencer with optional completion polling
//
// Takes (address, data, last) register-write commands and issues one single-beat
// 32-bit AXI4 write for each command. After the last command it can poll a status
// register until the accelerator reports completion. It pulses done_o when the
// sequence ends. err_o is sticky and is cleared by the next accepted command.
//
// Optional feature macro: CFG_SEQ_POLL_EN
//   defined     - after the last B, poll STATUS_ADDR every POLL_GAP cycles.
//                 A timeout is flagged after POLL_MAX polls.
//   not defined - after the last B, finish at once; ar_valid_o/r_ready_o tied 0.
//
// Ports:
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o     command handshake
//   cmd_addr_i/data_i/last_i    command payload
//   aw_* / w_* / b_*            AXI4 write channels (single beat, ID 0)
//   ar_* / r_*                  AXI4 read channels used for status polling
//   busy_o, done_o, err_o       status: not idle, end-of-sequence pulse, sticky error
module axi_cfg_sequencer #(
   parameter int                ADDR_W      = 64,
   parameter int                DATA_W      = 64,
   parameter int                ID_W        = 4,
   parameter logic [ADDR_W-1:0] STATUS_ADDR = 64'h5000_0030,
   parameter logic [31:0]       STATUS_MASK = 32'h0000_0001,
   parameter int                POLL_GAP    = 8,
   parameter int                POLL_MAX    = 1024
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                cmd_valid_i,
   output logic                cmd_ready_o,
   input  logic [ADDR_W-1:0]   cmd_addr_i,
   input  logic [31:0]         cmd_data_i,
   input  logic                cmd_last_i,
   output logic [ADDR_W-1:0]   aw_addr_o,
   output logic                aw_valid_o,
   input  logic                aw_ready_i,
   output logic [ID_W-1:0]     aw_id_o,
   output logic [2:0]          aw_size_o,
   output logic [7:0]          aw_len_o,
   output logic [1:0]          aw_burst_o,
   output logic [DATA_W-1:0]   w_data_o,
   output logic [DATA_W/8-1:0] w_strb_o,
   output logic                w_last_o,
   output logic                w_valid_o,
   input  logic                w_ready_i,
   input  logic                b_valid_i,
   output logic                b_ready_o,
   input  logic [1:0]          b_resp_i,
   input  logic [ID_W-1:0]     b_id_i,
   output logic [ADDR_W-1:0]   ar_addr_o,
   output logic                ar_valid_o,
   input  logic                ar_ready_i,
   output logic [ID_W-1:0]     ar_id_o,
   output logic [2:0]          ar_size_o,
   output logic [7:0]          ar_len_o,
   output logic [1:0]          ar_burst_o,
   input  logic                r_valid_i,
   output logic                r_ready_o,
   input  logic [DATA_W-1:0]   r_data_i,
   input  logic [1:0]          r_resp_i,
   input  logic                r_last_i,
   input  logic [ID_W-1:0]     r_id_i,
   output logic                busy_o,
   output logic                done_o,
   output logic                err_o
);

   typedef enum logic [2:0] {
      IDLE, WRITE, WRESP, POLL_WAIT, READ, RDATA, FINISH
   } state_t;

   state_t state;
   logic   last_q;

   assign aw_id_o    = '0;
   assign aw_size_o  = 3'b010;
   assign aw_len_o   = 8'h00;
   assign aw_burst_o = 2'b01;
   assign ar_id_o    = '0;
   assign ar_size_o  = 3'b010;
   assign ar_len_o   = 8'h00;
   assign ar_burst_o = 2'b01;
   assign w_last_o   = 1'b1;

`ifdef CFG_SEQ_POLL_EN
   localparam int GAP_W  = $clog2(POLL_GAP + 1);
   localparam int PCNT_W = $clog2(POLL_MAX + 1);

   logic [GAP_W-1:0]  gap_cnt;
   logic [PCNT_W-1:0] poll_cnt;
   logic [31:0]       r_word;

   // The status word sits in the lane selected by STATUS_ADDR[2].
   assign r_word = STATUS_ADDR[2] ? r_data_i[63:32] : r_data_i[31:0];

   logic unused_inputs;
   assign unused_inputs = ^{b_id_i, r_last_i, r_id_i};
`else
   assign ar_addr_o  = '0;
   assign ar_valid_o = 1'b0;
   assign r_ready_o  = 1'b0;

   logic unused_inputs;
   assign unused_inputs = ^{b_id_i, ar_ready_i, r_valid_i, r_data_i, r_resp_i,
                            r_last_i, r_id_i, STATUS_ADDR, STATUS_MASK,
                            POLL_GAP, POLL_MAX};
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= IDLE;
         last_q      <= 1'b0;
         cmd_ready_o <= 1'b0;
         aw_addr_o   <= '0;
         aw_valid_o  <= 1'b0;
         w_data_o    <= '0;
         w_strb_o    <= '0;
         w_valid_o   <= 1'b0;
         b_ready_o   <= 1'b0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         err_o       <= 1'b0;
`ifdef CFG_SEQ_POLL_EN
         ar_addr_o   <= '0;
         ar_valid_o  <= 1'b0;
         r_ready_o   <= 1'b0;
         gap_cnt     <= '0;
         poll_cnt    <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid_i && cmd_ready_o) begin
                  cmd_ready_o <= 1'b0;
                  busy_o      <= 1'b1;
                  err_o       <= 1'b0;
                  last_q      <= cmd_last_i;
                  aw_addr_o   <= cmd_addr_i;
                  aw_valid_o  <= 1'b1;
                  w_valid_o   <= 1'b1;
                  if (cmd_addr_i[2]) begin
                     w_data_o <= {cmd_data_i, 32'h0};
                     w_strb_o <= 8'hF0;
                  end else begin
                     w_data_o <= {32'h0, cmd_data_i};
                     w_strb_o <= 8'h0F;
                  end
                  state <= WRITE;
               end else begin
                  cmd_ready_o <= 1'b1;
               end
            end
            WRITE: begin
               // AW and W retire independently; a low valid means that
               // channel has already handshaken.
               if (aw_ready_i) aw_valid_o <= 1'b0;
               if (w_ready_i)  w_valid_o  <= 1'b0;
               if ((!aw_valid_o || aw_ready_i) && (!w_valid_o || w_ready_i)) begin
                  b_ready_o <= 1'b1;
                  state     <= WRESP;
               end
            end
            WRESP: begin
               if (b_valid_i) begin
                  b_ready_o <= 1'b0;
                  if (b_resp_i != 2'b00) begin
                     err_o  <= 1'b1;
                     done_o <= 1'b1;
                     state  <= FINISH;
                  end else if (!last_q) begin
                     cmd_ready_o <= 1'b1;
                     busy_o      <= 1'b0;
                     state       <= IDLE;
                  end else begin
`ifdef CFG_SEQ_POLL_EN
                     gap_cnt  <= '0;
                     poll_cnt <= '0;
                     state    <= POLL_WAIT;
`else
                     done_o <= 1'b1;
                     state  <= FINISH;
`endif
                  end
               end
            end
`ifdef CFG_SEQ_POLL_EN
            POLL_WAIT: begin
               if (gap_cnt == GAP_W'(POLL_GAP - 1)) begin
                  ar_addr_o  <= STATUS_ADDR;
                  ar_valid_o <= 1'b1;
                  state      <= READ;
               end else begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
            end
            READ: begin
               if (ar_ready_i) begin
                  ar_valid_o <= 1'b0;
                  r_ready_o  <= 1'b1;
                  state      <= RDATA;
               end
            end
            RDATA: begin
               if (r_valid_i) begin
                  r_ready_o <= 1'b0;
                  if (r_resp_i != 2'b00) begin
                     err_o  <= 1'b1;
                     done_o <= 1'b1;
                     state  <= FINISH;
                  end else if ((r_word & STATUS_MASK) != 32'h0) begin
                     done_o <= 1'b1;
                     state  <= FINISH;
                  end else if (poll_cnt == PCNT_W'(POLL_MAX - 1)) begin
                     err_o  <= 1'b1;
                     done_o <= 1'b1;
                     state  <= FINISH;
                  end else begin
                     poll_cnt <= poll_cnt + PCNT_W'(1);
                     gap_cnt  <= '0;
                     state    <= POLL_WAIT;
                  end
               end
            end
`endif
            FINISH: begin
               done_o      <= 1'b0;
               cmd_ready_o <= 1'b1;
               busy_o      <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
